oled_text_refresh: RTL
======================

// Module: oled_text_refresh
// PURPOSE
//  Parametrised ROWSxCOLS character-screen engine for the PmodOLED (SSD1306).
//  Holds a writable text buffer and tracks one dirty bit per row (page).
//  Streams only changed rows through SpiCtrl using 8x8 glyphs from charLib.
//  Sits between application logic (the calculator display) and SpiCtrl/charLib.
//  Replaces fixed-screen sequencing; power-up/Delay handling stays outside.
// PARAMETERS
//  ROWS       4      text rows = OLED pages; 1..8
//  COLS       16     characters per row; 1..16; each glyph is 8 columns
//  ROM_LAT    2      cycles from ROM_ADDR change to valid ROM_DOUT; 1..4
//  BLANK_CHAR 8'h20  character loaded into every cell at reset
//  RW         $clog2(ROWS) (min 1)  row-index width, derived
//  CW         $clog2(COLS) (min 1)  column-index width, derived
// PORTS
//  CLK       in   1    system clock
//  RST       in   1    asynchronous active-high reset
//  EN        in   1    refresh enable; level-sensitive
//  WR_EN     in   1    write strobe for one buffer cell; one cell per cycle
//  WR_ROW    in   RW   row of the write
//  WR_COL    in   CW   column of the write
//  WR_CHAR   in   8    ASCII code of the write
//  SPI_EN    out  1    request to SpiCtrl
//  SPI_DATA  out  8    byte to SpiCtrl; stable while SPI_EN=1
//  SPI_FIN   in   1    SpiCtrl done; high until SPI_EN drops
//  DC        out  1    0 = command, 1 = data
//  ROM_ADDR  out  11   {char,slice[2:0]} address to charLib
//  ROM_DOUT  in   8    charLib glyph byte
//  BUSY      out  1    high from row start to ROW_DONE inclusive
//  FIN       out  1    one-cycle pulse: refresh pass ended with no dirty rows
// BEHAVIOUR
//  Reset values:
//   - outputs: SPI_EN=0, SPI_DATA=0, DC=0, ROM_ADDR=0, BUSY=0, FIN=0
//   - all cells = BLANK_CHAR; all dirty bits = 1, so the first EN blanks the panel
//  Writes:
//   - accepted in any state, including mid-refresh
//   - cell updated on the next CLK; dirty[WR_ROW] set
//   - WR_ROW>=ROWS or WR_COL>=COLS: write ignored, no dirty bit set
//  FSM states and transitions:
//   - IDLE: if EN and |dirty, latch lowest dirty row r, clear dirty[r], BUSY=1 -> CMD
//   - CMD: DC=0; send 0x22, {5'b0,r}, 0x00, 0x10 through the SPI handshake
//   - DATA: DC=1; for col 0..COLS-1 and slice 0..7:
//     - ROM_ADDR={cell[r][col],slice}
//     - wait ROM_LAT cycles, SPI_DATA<=ROM_DOUT, SPI handshake
//   - ROW_DONE: BUSY=0 -> IDLE
//     - if EN=1 and no dirty bit set: FIN pulses in this cycle
//  SPI handshake, per byte:
//   - SPI_DATA set one cycle before SPI_EN rises
//   - SPI_EN held until SPI_FIN is sampled 1, then dropped
//   - next byte starts only after SPI_FIN is sampled 0
//  Latency: one row = 4 + 8*COLS SPI bytes; first SPI_EN no later than 3 CLKs after start.
//  Same-row write mid-refresh: the cell is read live, so the glyph may tear.
//    dirty[r] is set again, so the row is resent and the final frame is exact.
//  EN low mid-row: the current row completes; the engine then stays in IDLE.
//  RST mid-operation: immediate abort to reset values; SpiCtrl resets on the same RST.
//  Row priority: lowest index first; a row rewritten continuously can starve higher rows.
//    This is accepted.
// TESTING
//  1. Reset, EN=1, SpiCtrl model with FIN 3 CLK after EN:
//     -> 4 rows x (4 cmd + 128 data) bytes; every data byte equals the glyph of 0x20;
//     -> FIN pulses once.
//  2. Idle, then write (1,5,'A'):
//     -> only page 1 is sent: cmd bytes 22,01,00,10;
//     -> data bytes 40-47 are charLib{0x41,0..7}; FIN pulses.
//  3. Write (2,0,'B') while page 2 is at byte 10:
//     -> page 2 is sent twice; the second pass has 'B' at column 0.
//  4. Write (ROWS,0,'X') or (0,COLS,'X'):
//     -> no dirty bit set; no SPI activity; buffer unchanged.
//  5. Drop EN during page 0:
//     -> page 0 completes, then no SPI_EN; re-raise EN -> pages 1-3 follow.
//  6. Assert RST mid-byte:
//     -> SPI_EN=0 and BUSY=0 within the same cycle; after release the full blank refresh restarts.
//     -> Repeat with ROM_LAT=1 and with ROWS=8, COLS=12.

Source files
------------

// File: rtl/oled_text_refresh_if.sv
// Engine-side bus for oled_text_refresh: buffer write port, SpiCtrl handshake
// and charLib glyph ROM. The engine uses the master modport.
interface oled_text_refresh_if #(
  parameter int RW = 2,
  parameter int CW = 4
);
  logic          wr_en;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic [7:0]    wr_char;
  logic          spi_en;
  logic [7:0]    spi_data;
  logic          spi_fin;
  logic          dc;
  logic [10:0]   rom_addr;
  logic [7:0]    rom_dout;

  modport master (
    input  wr_en, wr_row, wr_col, wr_char, spi_fin, rom_dout,
    output spi_en, spi_data, dc, rom_addr
  );

  modport slave (
    output wr_en, wr_row, wr_col, wr_char, spi_fin, rom_dout,
    input  spi_en, spi_data, dc, rom_addr
  );
endinterface

// File: rtl/oled_text_refresh.sv
// ROWSxCOLS character-screen engine for the SSD1306 PmodOLED. Keeps a text
// buffer with one dirty bit per page and streams only dirty pages to SpiCtrl,
// fetching 8x8 glyph slices from charLib.
module oled_text_refresh #(
  parameter int         ROWS       = 4,
  parameter int         COLS       = 16,
  parameter int         ROM_LAT    = 2,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  oled_text_refresh_if.master bus,
  output logic               busy,
  output logic               fin
);
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int COLS_M1 = COLS - 1;
  localparam logic [RW:0]   ROW_LIM  = ROWS[RW:0];
  localparam logic [CW:0]   COL_LIM  = COLS[CW:0];
  localparam logic [CW-1:0] LAST_COL = COLS_M1[CW-1:0];
  localparam logic [2:0]    LAT      = ROM_LAT[2:0];

  // Each byte goes SETUP (data stable, SPI_EN low) -> SEND (SPI_EN high until
  // FIN) -> REL (wait for FIN low). Data bytes first wait out the ROM latency.
  typedef enum logic [3:0] {
    IDLE, CMD_SETUP, CMD_SEND, CMD_REL,
    DATA_ROM, DATA_SETUP, DATA_SEND, DATA_REL, ROW_DONE
  } state_t;

  state_t state, state_n;

  logic [ROWS-1:0][COLS-1:0][7:0] cells;
  logic [ROWS-1:0]                dirty;
  logic [RW-1:0]                  row, low_row;
  logic [1:0]                     cmd_idx;
  logic [CW-1:0]                  col, col_n;
  logic [2:0]                     slice, slice_n;
  logic [2:0]                     lat_cnt;
  logic [7:0]                     spi_data;
  logic [10:0]                    rom_addr;
  logic                           start, wr_ok, last_byte;

  // Page-address command sequence: page = row, column start = 0.
  function automatic logic [7:0] cmd_byte(input logic [1:0] idx, input logic [RW-1:0] r);
    case (idx)
      2'd0:    cmd_byte = 8'h22;
      2'd1:    cmd_byte = 8'(r);
      2'd2:    cmd_byte = 8'h00;
      default: cmd_byte = 8'h10;
    endcase
  endfunction

  assign wr_ok     = bus.wr_en && ({1'b0, bus.wr_row} < ROW_LIM) && ({1'b0, bus.wr_col} < COL_LIM);
  assign start     = (state == IDLE) && en && (|dirty);
  assign last_byte = (slice == 3'd7) && (col == LAST_COL);
  assign slice_n   = slice + 3'd1;
  assign col_n     = (slice == 3'd7) ? col + CW'(1) : col;

  // Lowest-index dirty row wins.
  always_comb begin
    low_row = '0;
    for (int i = ROWS - 1; i >= 0; i--)
      if (dirty[i]) low_row = RW'(i);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       if (start) state_n = CMD_SETUP;
      CMD_SETUP:  state_n = CMD_SEND;
      CMD_SEND:   if (bus.spi_fin) state_n = CMD_REL;
      CMD_REL:    if (!bus.spi_fin) state_n = (cmd_idx == 2'd3) ? DATA_ROM : CMD_SETUP;
      DATA_ROM:   if (lat_cnt == LAT) state_n = DATA_SETUP;
      DATA_SETUP: state_n = DATA_SEND;
      DATA_SEND:  if (bus.spi_fin) state_n = DATA_REL;
      DATA_REL:   if (!bus.spi_fin) state_n = last_byte ? ROW_DONE : DATA_ROM;
      ROW_DONE:   state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  assign bus.spi_en   = (state == CMD_SEND) || (state == DATA_SEND);
  assign bus.dc       = (state == DATA_ROM) || (state == DATA_SETUP) ||
                        (state == DATA_SEND) || (state == DATA_REL);
  assign bus.spi_data = spi_data;
  assign bus.rom_addr = rom_addr;
  assign busy         = (state != IDLE);
  assign fin          = (state == ROW_DONE) && en && !(|dirty);

  // Text buffer and dirty bits; a write in the start cycle re-marks the row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cells <= {(ROWS * COLS){BLANK_CHAR}};
      dirty <= '1;
    end else begin
      if (start) dirty[low_row] <= 1'b0;
      if (wr_ok) begin
        cells[bus.wr_row][bus.wr_col] <= bus.wr_char;
        dirty[bus.wr_row]             <= 1'b1;
      end
    end
  end

  // Byte sequencing datapath: row latch, counters, SPI byte and ROM address.
  // Cells are read live when each ROM address is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row      <= '0;
      cmd_idx  <= '0;
      col      <= '0;
      slice    <= '0;
      lat_cnt  <= '0;
      spi_data <= '0;
      rom_addr <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          row      <= low_row;
          cmd_idx  <= 2'd0;
          spi_data <= 8'h22;
        end
        CMD_REL: if (!bus.spi_fin) begin
          if (cmd_idx == 2'd3) begin
            col      <= '0;
            slice    <= 3'd0;
            lat_cnt  <= 3'd0;
            rom_addr <= {cells[row][0], 3'd0};
          end else begin
            cmd_idx  <= cmd_idx + 2'd1;
            spi_data <= cmd_byte(cmd_idx + 2'd1, row);
          end
        end
        DATA_ROM: begin
          lat_cnt <= lat_cnt + 3'd1;
          if (lat_cnt == LAT) spi_data <= bus.rom_dout;
        end
        DATA_REL: if (!bus.spi_fin && !last_byte) begin
          col      <= col_n;
          slice    <= slice_n;
          lat_cnt  <= 3'd0;
          rom_addr <= {cells[row][col_n], slice_n};
        end
        default: ;
      endcase
    end
  end
endmodule
